// File: rtl/cpu_types_pkg.sv
// Shared CPU types used by the memory arbiter and its helpers.
//   word_t      : 32-bit machine word
//   ramstate_t  : unified RAM handshake state reported by the RAM model
//   arb_state_t : arbiter FSM state
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Watchdog for a RAM grant that never sees ACCESS.
//   CLK, nRST : clock, async active-low reset
//   clr       : zero the count (held while the arbiter is idle)
//   en        : a grant cycle that did not complete
//   expired   : this enabled cycle is the TIMEOUT-th without completion
module mem_timeout_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);
    localparam logic [W-1:0] LAST  = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && (count != LIMIT))
            count <= count + W'(1);
    end

    // Flag the expiring cycle itself so the arbiter leaves the grant after
    // exactly TIMEOUT waiting cycles rather than one cycle later.
    assign expired = en && (count >= LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the single unified RAM port shared by instruction fetch and
// data access. Priority alternates under contention; a watchdog aborts a
// grant the RAM never answers and sets the sticky memerr flag.
//   CLK, nRST                 : clock, async active-low reset
//   iREN, iaddr / iwait, iload: instruction requester
//   dREN, dWEN, daddr, dstore / dwait, dload : data requester
//   ramREN, ramWEN, ramaddr, ramstore / ramload, ramstate : RAM port
//   memerr                    : sticky timeout flag, cleared by reset only
//
// state | meaning
// IDLE  | no grant, RAM port quiet, arbitrating
// IGNT  | instruction side drives the RAM port
// DGNT  | data side drives the RAM port
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      memerr
);

    arb_state_t state, state_nxt;
    logic       last_d, last_d_nxt;
    logic       memerr_set;
    logic       d_req;
    logic       access;
    logic       expired;

    assign d_req  = dREN | dWEN;
    assign access = (ramstate == ACCESS);
    assign iload  = ramload;
    assign dload  = ramload;

    // ACCESS masks the enable, so a completion always beats a timeout.
    mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .CLK     (CLK),
        .nRST    (nRST),
        .clr     (state == IDLE),
        .en      ((state != IDLE) && !access),
        .expired (expired)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            last_d <= 1'b0;
            memerr <= 1'b0;
        end else begin
            state  <= state_nxt;
            last_d <= last_d_nxt;
            if (memerr_set)
                memerr <= 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        last_d_nxt = last_d;
        memerr_set = 1'b0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        case (state)
            IDLE: begin
                if (d_req && (!last_d || !iREN)) begin
                    state_nxt  = DGNT;
                    last_d_nxt = 1'b1;
                end else if (iREN) begin
                    state_nxt  = IGNT;
                    last_d_nxt = 1'b0;
                end
            end
            IGNT: begin
                ramaddr = iaddr;
                ramREN  = iREN;   // drops at once if the fetch is withdrawn
                if (!iREN) begin
                    state_nxt = IDLE;
                end else if (access) begin
                    iwait     = 1'b0;
                    state_nxt = IDLE;
                end else if (expired) begin
                    memerr_set = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            DGNT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (!d_req) begin
                    state_nxt = IDLE;
                end else if (access) begin
                    dwait     = 1'b0;
                    state_nxt = IDLE;
                end else if (expired) begin
                    memerr_set = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore, ramload;
    ramstate_t ramstate;
    logic      iwait, dwait, ramREN, ramWEN, memerr;
    word_t     iload, dload, ramaddr, ramstore;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic  is_d;
        word_t addr;
        word_t data;
        logic  we;
    } exp_t;

    exp_t expq[$];

    always #5 CLK = ~CLK;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .memerr(memerr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic is_d, input word_t addr, input word_t data, input logic we);
        exp_t e;
        e.is_d = is_d;
        e.addr = addr;
        e.data = data;
        e.we   = we;
        expq.push_back(e);
    endtask

    task automatic clear_reqs();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        ramstate = FREE;
    endtask

    // Completion monitor: every low wait must match the next queued transfer.
    always @(negedge CLK) begin
        if (nRST && (!iwait || !dwait)) begin
            exp_t e;
            if (!iwait && !dwait)
                chk("both_waits_low", 32'd1, 32'd0);
            if (expq.size() == 0) begin
                chk("unexpected_completion", 32'd1, 32'd0);
            end else begin
                e = expq.pop_front();
                chk("cmp_side", {31'd0, !dwait}, {31'd0, e.is_d});
                chk("cmp_addr", ramaddr, e.addr);
                chk("cmp_data", e.is_d ? dload : iload, e.data);
                chk("cmp_we", {31'd0, ramWEN}, {31'd0, e.we});
            end
        end
    end

    initial begin
        nRST = 1'b0;
        clear_reqs();
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
        #12;
        chk("rst_iwait", {31'd0, iwait}, 32'd1);
        chk("rst_dwait", {31'd0, dwait}, 32'd1);
        chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
        chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_ramstore", ramstore, 32'd0);
        chk("rst_memerr", {31'd0, memerr}, 32'd0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        step();

        // I-only with immediate ACCESS; back-to-back grants two cycles apart.
        iREN = 1'b1; iaddr = 32'h100; ramload = 32'h3C010001; ramstate = ACCESS;
        push(1'b0, 32'h100, 32'h3C010001, 1'b0);
        chk("i_c0_iwait", {31'd0, iwait}, 32'd1);
        step();
        chk("i_c1_ramREN", {31'd0, ramREN}, 32'd1);
        chk("i_c1_ramaddr", ramaddr, 32'h100);
        chk("i_c1_iwait", {31'd0, iwait}, 32'd0);
        chk("i_c1_iload", iload, 32'h3C010001);
        push(1'b0, 32'h100, 32'h3C010001, 1'b0);
        step();
        chk("i_c2_ramREN", {31'd0, ramREN}, 32'd0);
        chk("i_c2_iwait", {31'd0, iwait}, 32'd1);
        step();
        chk("i_c3_iwait", {31'd0, iwait}, 32'd0);
        step();
        clear_reqs();
        step();

        // Contention: D, I, D, I with one dead cycle between each.
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h200; daddr = 32'h300;
        ramload = 32'h11111111; ramstate = ACCESS;
        push(1'b1, 32'h300, 32'h11111111, 1'b0);
        push(1'b0, 32'h200, 32'h11111111, 1'b0);
        push(1'b1, 32'h300, 32'h11111111, 1'b0);
        push(1'b0, 32'h200, 32'h11111111, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("cont_c%0d_dwait", k), {31'd0, dwait},
                (k == 1 || k == 5) ? 32'd0 : 32'd1);
            chk($sformatf("cont_c%0d_iwait", k), {31'd0, iwait},
                (k == 3 || k == 7) ? 32'd0 : 32'd1);
        end
        step();
        clear_reqs();
        step();

        // Write dominates read within a data grant.
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEADBEEF;
        ramload = 32'hCAFE0000; ramstate = ACCESS;
        push(1'b1, 32'h80, 32'hCAFE0000, 1'b1);
        step();
        chk("wr_ramWEN", {31'd0, ramWEN}, 32'd1);
        chk("wr_ramREN", {31'd0, ramREN}, 32'd0);
        chk("wr_ramstore", ramstore, 32'hDEADBEEF);
        chk("wr_ramaddr", ramaddr, 32'h80);
        step();
        clear_reqs();
        dstore = '0;
        step();

        // Three BUSY cycles then ACCESS; ACCESS lands on the would-be timeout cycle.
        dREN = 1'b1; daddr = 32'h44; ramload = 32'h12345678; ramstate = BUSY;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("ws_c%0d_dwait", k), {31'd0, dwait}, 32'd1);
            chk($sformatf("ws_c%0d_ramREN", k), {31'd0, ramREN}, 32'd1);
        end
        step();
        ramstate = ACCESS;
        push(1'b1, 32'h44, 32'h12345678, 1'b0);
        #1;
        chk("ws_c4_dwait", {31'd0, dwait}, 32'd0);
        step();
        clear_reqs();
        chk("ws_memerr", {31'd0, memerr}, 32'd0);
        step();

        // Timeout after four BUSY grant cycles, sticky flag, re-grant, withdrawal.
        iREN = 1'b1; iaddr = 32'h500; ramstate = BUSY;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("to_c%0d_ramREN", k), {31'd0, ramREN}, 32'd1);
            chk($sformatf("to_c%0d_memerr", k), {31'd0, memerr}, 32'd0);
        end
        step();
        chk("to_c5_memerr", {31'd0, memerr}, 32'd1);
        chk("to_c5_ramREN", {31'd0, ramREN}, 32'd0);
        chk("to_c5_iwait", {31'd0, iwait}, 32'd1);
        step();
        chk("to_c6_regrant", {31'd0, ramREN}, 32'd1);
        iREN = 1'b0;
        #1;
        chk("to_c6_withdraw_ramREN", {31'd0, ramREN}, 32'd0);
        chk("to_c6_iwait", {31'd0, iwait}, 32'd1);
        step();
        chk("to_c7_memerr", {31'd0, memerr}, 32'd1);
        clear_reqs();
        step();

        // Data withdrawal mid-BUSY.
        dREN = 1'b1; daddr = 32'h700; ramstate = BUSY;
        step();
        chk("wd_c1_ramREN", {31'd0, ramREN}, 32'd1);
        chk("wd_c1_ramaddr", ramaddr, 32'h700);
        step();
        dREN = 1'b0;
        #1;
        chk("wd_c2_ramREN", {31'd0, ramREN}, 32'd0);
        chk("wd_c2_dwait", {31'd0, dwait}, 32'd1);
        step();
        chk("wd_c3_ramaddr", ramaddr, 32'h0);
        chk("wd_c3_memerr", {31'd0, memerr}, 32'd1);
        clear_reqs();
        step();

        // Asynchronous reset during an instruction grant.
        iREN = 1'b1; iaddr = 32'h600; ramstate = BUSY;
        step();
        chk("rr_c1_ramREN", {31'd0, ramREN}, 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        chk("rr_ramREN", {31'd0, ramREN}, 32'd0);
        chk("rr_ramaddr", ramaddr, 32'h0);
        chk("rr_iwait", {31'd0, iwait}, 32'd1);
        chk("rr_memerr", {31'd0, memerr}, 32'd0);
        clear_reqs();
        step();
        nRST = 1'b1;
        step();
        step();

        chk("queue_drained", expq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
